// File: rtl/uart_io.sv
// uart_io: UART byte responder for the core's send/recv handshakes. TX FIFO feeds an 8N1 serializer,
// and an rxd deserializer feeds the RX FIFO. Define UART_LOOPBACK_EN to feed the RX path from the internal txd.
module uart_io #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_send_ready,
    input  logic [7:0] uart_send_data,
    output logic       uart_send_done,
    input  logic       uart_recv_ready,
    output logic       uart_recv_valid,
    output logic [7:0] uart_recv_data,
    output logic       txd,
    input  logic       rxd,
    output logic       rx_overrun,
    output logic       rx_frame_err
);
    localparam int TW = $clog2(CLK_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

    // ---------------- FIFO storage and pointers ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q;
    logic [CW-1:0] tx_cnt_q;
    logic          tx_push, tx_push_ok, tx_pop;
    logic [7:0]    tx_push_data;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_q, rx_rd_q;
    logic [CW-1:0] rx_cnt_q;
    logic          rx_push, rx_push_ok, rx_pop;

    // ---------------- handshake state ----------------
    logic       send_pend_q, send_pend_d;
    logic [7:0] send_byte_q, send_byte_d;
    logic       send_done_q, send_done_d;
    logic       recv_pend_q, recv_pend_d;
    logic       recv_valid_q, recv_valid_d;
    logic [7:0] recv_data_q, recv_data_d;
    logic       recv_req;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;

    // ---------------- TX serializer state ----------------
    uart_state_e   tx_state_q, tx_state_d;
    logic [TW-1:0] tx_tmr_q, tx_tmr_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          tx_load;

    // ---------------- RX deserializer state ----------------
    uart_state_e   rx_state_q, rx_state_d;
    logic [TW-1:0] rx_tmr_q, rx_tmr_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_src;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;

`ifdef UART_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = rxd;
    assign rx_src     = tx_q;
`else
    assign rx_src     = rxd;
`endif

    // A refused send is held in send_byte_q and retried every cycle until the FIFO takes it.
    always_comb begin
        tx_push      = send_pend_q | uart_send_ready;
        tx_push_data = send_pend_q ? send_byte_q : uart_send_data;
        tx_push_ok   = tx_push & ((tx_cnt_q < DEPTH_C) | tx_pop);
        send_done_d  = tx_push_ok;
        send_pend_d  = tx_push & ~tx_push_ok;
        send_byte_d  = tx_push_data;
    end

    // A request in the same cycle as a non-empty FIFO is served at once (1-cycle latency).
    always_comb begin
        recv_req     = recv_pend_q | uart_recv_ready;
        rx_pop       = recv_req & (rx_cnt_q != '0);
        recv_pend_d  = recv_req & ~rx_pop;
        recv_valid_d = rx_pop;
        recv_data_d  = rx_pop ? rx_mem[rx_rd_q] : recv_data_q;
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            send_pend_q  <= 1'b0;
            send_byte_q  <= 8'h00;
            send_done_q  <= 1'b0;
            recv_pend_q  <= 1'b0;
            recv_valid_q <= 1'b0;
            recv_data_q  <= 8'h00;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            send_pend_q  <= send_pend_d;
            send_byte_q  <= send_byte_d;
            send_done_q  <= send_done_d;
            recv_pend_q  <= recv_pend_d;
            recv_valid_q <= recv_valid_d;
            recv_data_q  <= recv_data_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push_ok) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)     tx_rd_q <= tx_rd_q + 1'b1;
            if (tx_push_ok != tx_pop)
                tx_cnt_q <= tx_push_ok ? tx_cnt_q + 1'b1 : tx_cnt_q - 1'b1;
            if (rx_push_ok) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)     rx_rd_q <= rx_rd_q + 1'b1;
            if (rx_push_ok != rx_pop)
                rx_cnt_q <= rx_push_ok ? rx_cnt_q + 1'b1 : rx_cnt_q - 1'b1;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; pointers and count alone define valid entries.
    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wr_q] <= tx_push_data;
        if (rx_push_ok) rx_mem[rx_wr_q] <= rx_shift_q;
    end

    // TX FSM: STOP falls through into the IDLE load so consecutive frames are gap-free.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        tx_state_d = tx_state_q;
        tx_tmr_d   = tx_tmr_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        case (tx_state_q)
            ST_IDLE: tx_load = 1'b1;
            ST_START: begin
                if (tx_tmr_q == '0) begin
                    tx_state_d = ST_DATA;
                    tx_tmr_d   = BIT_LAST;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_tmr_d = tx_tmr_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_tmr_q == '0) begin
                    tx_tmr_d = BIT_LAST;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_tmr_d = tx_tmr_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_tmr_q == '0) tx_load = 1'b1;
                else                tx_tmr_d = tx_tmr_q - 1'b1;
            end
            default: tx_load = 1'b1;
        endcase
        if (tx_load) begin
            tx_state_d = ST_IDLE;
            tx_d       = 1'b1;
            if (tx_cnt_q != '0) begin
                tx_pop     = 1'b1;
                tx_state_d = ST_START;
                tx_d       = 1'b0;
                tx_shift_d = tx_mem[tx_rd_q];
                tx_tmr_d   = BIT_LAST;
            end
        end
    end

    // RX FSM: START is checked at half a bit, so every later sample lands mid-bit.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tmr_d    = rx_tmr_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        frame_err_d = frame_err_q;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = ST_START;
                    rx_tmr_d   = HALF_LAST;
                end
            end
            ST_START: begin
                if (rx_tmr_q == '0) begin
                    if (rx_sync_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_tmr_d   = BIT_LAST;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_tmr_d = rx_tmr_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_tmr_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_tmr_d   = BIT_LAST;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_tmr_d = rx_tmr_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_tmr_q == '0) begin
                    rx_state_d = ST_IDLE;
                    if (rx_sync_q) rx_push     = 1'b1;
                    else           frame_err_d = 1'b1;
                end else begin
                    rx_tmr_d = rx_tmr_q - 1'b1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
        rx_push_ok = rx_push & ((rx_cnt_q < DEPTH_C) | rx_pop);
        overrun_d  = overrun_q | (rx_push & ~rx_push_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_tmr_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_q       <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_tmr_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tmr_q   <= tx_tmr_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_tmr_q   <= rx_tmr_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= rx_src;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
        end
    end

    assign uart_send_done  = send_done_q;
    assign uart_recv_valid = recv_valid_q;
    assign uart_recv_data  = recv_data_q;
    assign txd             = tx_q;
    assign rx_overrun      = overrun_q;
    assign rx_frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_io.sv
// Randomized bench for uart_io (CLK_PER_BIT=4, FIFO_DEPTH=4); a queue-based model predicts RX deliveries and flags.
module tb_uart_io;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_send_ready = 1'b0;
    logic [7:0] uart_send_data = 8'h00;
    logic       uart_send_done;
    logic       uart_recv_ready = 1'b0;
    logic       uart_recv_valid;
    logic [7:0] uart_recv_data;
    logic       txd;
    logic       rxd = 1'b1;
    logic       rx_overrun;
    logic       rx_frame_err;

    uart_io #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .uart_send_ready(uart_send_ready), .uart_send_data(uart_send_data), .uart_send_done(uart_send_done),
        .uart_recv_ready(uart_recv_ready), .uart_recv_valid(uart_recv_valid), .uart_recv_data(uart_recv_data),
        .txd(txd), .rxd(rxd), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
        end
    endtask

    // Every recv_valid pulse observed on the DUT, in order.
    logic [7:0] got_q[$];
    always @(posedge clk) begin
        #1;
        if (uart_recv_valid === 1'b1) got_q.push_back(uart_recv_data);
    end

    // Reference model: RX FIFO contents, pending request, expected deliveries, sticky flags.
    logic [7:0] m_fifo[$];
    logic [7:0] m_exp[$];
    bit         m_pend = 1'b0;
    bit         m_ovr  = 1'b0;
    bit         m_ferr = 1'b0;
    logic [7:0] tx_exp_q[$];

    function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)                     m_ferr = 1'b1;
        else if (m_fifo.size() == DEPTH)  m_ovr  = 1'b1;
        else                              m_fifo.push_back(b);
        if (m_pend && m_fifo.size() > 0) begin
            m_exp.push_back(m_fifo.pop_front());
            m_pend = 1'b0;
        end
    endfunction

    function automatic void model_recv();
        if (m_fifo.size() > 0) m_exp.push_back(m_fifo.pop_front());
        else                   m_pend = 1'b1;
    endfunction

    task automatic drive_rx(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = fr[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        model_frame(b, stop_ok);
    endtask

    task automatic do_recv();
        @(negedge clk);
        uart_recv_ready = 1'b1;
        @(negedge clk);
        uart_recv_ready = 1'b0;
        model_recv();
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_cnt"}, 64'(got_q.size()), 64'(m_exp.size()));
        while (got_q.size() > 0 && m_exp.size() > 0)
            check({tag, "_data"}, 64'(got_q.pop_front()), 64'(m_exp.pop_front()));
        got_q.delete();
        m_exp.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_wait, output int lat);
        @(negedge clk);
        uart_send_ready = 1'b1;
        uart_send_data  = b;
        @(negedge clk);
        uart_send_ready = 1'b0;
        uart_send_data  = 8'($urandom);
        lat = 1;
        while (uart_send_done !== 1'b1 && lat < max_wait) begin
            @(negedge clk);
            lat++;
        end
        check("send_done_seen", 64'(uart_send_done), 64'd1);
    endtask

    // Samples txd once per clock from the first start-bit sample and compares whole frames.
    task automatic capture_tx(input string tag, input int n);
        int t;
        t = 0;
        while (txd !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (txd !== 1'b0) begin
            check({tag, "_start"}, 64'(txd), 64'd0);
            return;
        end
        for (int f = 0; f < n; f++) begin
            logic [39:0] got_v, exp_v;
            logic [9:0]  fr;
            fr = {1'b1, tx_exp_q[f], 1'b0};
            for (int k = 0; k < 10 * CPB; k++) begin
                exp_v[k] = fr[k / CPB];
                got_v[k] = txd;
                @(negedge clk);
            end
            check({tag, "_frame"}, 64'(got_v), 64'(exp_v));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int zeros;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_txd", 64'(txd), 64'd1);
        check("rst_send_done", 64'(uart_send_done), 64'd0);
        check("rst_recv_valid", 64'(uart_recv_valid), 64'd0);
        check("rst_recv_data", 64'(uart_recv_data), 64'd0);
        check("rst_overrun", 64'(rx_overrun), 64'd0);
        check("rst_frame_err", 64'(rx_frame_err), 64'd0);
        rst = 1'b0;

        // Reset mid-frame with a second byte queued: nothing may survive
        send_byte(8'h11, 10, lat);
        send_byte(8'h22, 10, lat);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_txd", 64'(txd), 64'd1);
        check("midrst_send_done", 64'(uart_send_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        zeros = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1) zeros++;
        end
        check("midrst_no_residual", 64'(zeros), 64'd0);

        // Single byte 0xA5: done one cycle later, exact 40-clock frame
        tx_exp_q.delete();
        tx_exp_q.push_back(8'hA5);
        send_byte(8'hA5, 10, lat);
        check("send_lat", 64'(lat), 64'd1);
        capture_tx("tx_a5", 1);

        // Random singles
        for (int i = 0; i < 3; i++) begin
            tx_exp_q.delete();
            tx_exp_q.push_back(8'($urandom));
            send_byte(tx_exp_q[0], 10, lat);
            check("send_lat_rand", 64'(lat), 64'd1);
            capture_tx("tx_rand", 1);
        end

        // Burst overfilling the TX FIFO: last send pends, frames stay gap-free and ordered
        tx_exp_q.delete();
        for (int i = 0; i < 6; i++) tx_exp_q.push_back(8'($urandom));
        fork
            begin
                int blat;
                for (int i = 0; i < 6; i++) send_byte(tx_exp_q[i], 200, blat);
            end
            capture_tx("tx_burst", 6);
        join

`ifdef UART_LOOPBACK_EN
        // Loopback: TX feeds RX internally
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        send_byte(8'h5A, 10, lat);
        repeat (60) @(negedge clk);
        m_fifo.delete();
        m_fifo.push_back(8'h5A);
        do_recv();
        compare_rx("loopback");
`else
        // Received byte then request: 1-cycle latency
        drive_rx(8'h3C, 1'b1);
        do_recv();
        compare_rx("rx_3c");

        // Request on empty FIFO waits for the next byte
        do_recv();
        repeat (8) @(negedge clk);
        compare_rx("rx_empty_wait");
        drive_rx(8'h81, 1'b1);
        compare_rx("rx_pend_81");

        // Overrun: five frames into a four-deep FIFO
        for (int i = 1; i <= 5; i++) drive_rx(8'(i), 1'b1);
        check("rx_overrun", 64'(rx_overrun), 64'(m_ovr));
        for (int i = 0; i < 4; i++) begin
            do_recv();
            compare_rx("rx_ovr_drain");
        end

        // Framing error: byte discarded, FIFO stays empty
        drive_rx(8'h55, 1'b0);
        check("rx_frame_err", 64'(rx_frame_err), 64'(m_ferr));
        do_recv();
        repeat (8) @(negedge clk);
        compare_rx("rx_ferr_empty");

        // Random mix of frames (some with bad stop bits) and requests
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                drive_rx(8'($urandom), $urandom_range(0, 9) != 0);
                compare_rx("rx_rand_frame");
            end else begin
                do_recv();
                compare_rx("rx_rand_recv");
            end
        end
        check("final_overrun", 64'(rx_overrun), 64'(m_ovr));
        check("final_frame_err", 64'(rx_frame_err), 64'(m_ferr));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
